// File: rtl/serial_port_arbiter.sv
// Round-robin arbiter sharing the WiFi/Bluetooth 16550 register ports and WiFi reset line between two requesters.
// Define SERIAL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module serial_port_arbiter #(
  parameter int unsigned ACCESS_CYCLES    = 4,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic [1:0]  Req_Valid,
  output logic [1:0]  Req_Ready,
  input  logic [3:0]  Req_Port,
  input  logic [1:0]  Req_Write,
  input  logic [5:0]  Req_Reg,
  input  logic [15:0] Req_WrData,
  output logic [1:0]  Resp_Valid,
  output logic        Resp_Err,
  output logic [7:0]  Resp_RdData,
  output logic        WiFi_Port_Enable,
  output logic        Bluetooth_Port_Enable,
  output logic        WiFi_RST_n,
  output logic [2:0]  Uart_Reg,
  output logic        Uart_Write,
  output logic [7:0]  Uart_WrData,
  input  logic [7:0]  Uart_RdData
);

  typedef enum logic [1:0] {IDLE, ACCESS, PULSE, RESPOND} state_t;

  localparam logic [7:0] ACC_LAST = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_PULSE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        own_q, own_d;
  logic [1:0]  port_q, port_d;
  logic        wr_q, wr_d;
  logic [2:0]  reg_q, reg_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        win;
  logic [1:0]  ready;

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign win = Req_Valid[0] ? 1'b0 : 1'b1;
`else
  // On a tie the requester that did not win last time is served.
  assign win = (&Req_Valid) ? ~ptr_q : Req_Valid[1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    port_d  = port_q;
    wr_d    = wr_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (|Req_Valid) begin
          ready[win] = 1'b1;
          own_d      = win;
          ptr_d      = win;
          port_d     = win ? Req_Port[3:2]    : Req_Port[1:0];
          wr_d       = win ? Req_Write[1]     : Req_Write[0];
          reg_d      = win ? Req_Reg[5:3]     : Req_Reg[2:0];
          wd_d       = win ? Req_WrData[15:8] : Req_WrData[7:0];
          cnt_d      = '0;
          rdata_d    = '0;
          unique case (win ? Req_Port[3:2] : Req_Port[1:0])
            2'd0, 2'd1: state_d = ACCESS;
            2'd2:       state_d = PULSE;
            default: begin
              state_d = RESPOND;
              rdata_d = '1;
            end
          endcase
        end
      end
      ACCESS: begin
        if (cnt_q == ACC_LAST) begin
          if (!wr_q) rdata_d = Uart_RdData;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PULSE: begin
        if (cnt_q == RST_LAST) state_d = RESPOND;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      own_q   <= 1'b0;
      port_q  <= '0;
      wr_q    <= 1'b0;
      reg_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  // Accept is combinational in IDLE so the grant cycle is the cycle the request is seen.
  assign Req_Ready             = Reset_H ? 2'b00 : ready;
  assign Resp_Valid            = (state_q == RESPOND) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign Resp_Err              = (state_q == RESPOND) && (port_q == 2'd3);
  assign Resp_RdData           = rdata_q;
  assign WiFi_Port_Enable      = (state_q == ACCESS) && (port_q == 2'd0);
  assign Bluetooth_Port_Enable = (state_q == ACCESS) && (port_q == 2'd1);
  assign WiFi_RST_n            = (state_q != PULSE);
  assign Uart_Reg              = reg_q;
  assign Uart_Write            = (state_q == ACCESS) && wr_q;
  assign Uart_WrData           = wd_q;

endmodule

// File: tb/tb_serial_port_arbiter.sv
// Directed, table-driven bench for serial_port_arbiter, plus arbitration and reset-abort sequences.
module tb_serial_port_arbiter;
  localparam int unsigned ACC  = 4;
  localparam int unsigned RSTP = 16;

  logic        Clock = 1'b0;
  logic        Reset_H;
  logic [1:0]  Req_Valid;
  logic [1:0]  Req_Ready;
  logic [3:0]  Req_Port;
  logic [1:0]  Req_Write;
  logic [5:0]  Req_Reg;
  logic [15:0] Req_WrData;
  logic [1:0]  Resp_Valid;
  logic        Resp_Err;
  logic [7:0]  Resp_RdData;
  logic        WiFi_Port_Enable;
  logic        Bluetooth_Port_Enable;
  logic        WiFi_RST_n;
  logic [2:0]  Uart_Reg;
  logic        Uart_Write;
  logic [7:0]  Uart_WrData;
  logic [7:0]  Uart_RdData;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  serial_port_arbiter #(.ACCESS_CYCLES(ACC), .RST_PULSE_CYCLES(RSTP)) dut (
    .Clock(Clock), .Reset_H(Reset_H),
    .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Port(Req_Port),
    .Req_Write(Req_Write), .Req_Reg(Req_Reg), .Req_WrData(Req_WrData),
    .Resp_Valid(Resp_Valid), .Resp_Err(Resp_Err), .Resp_RdData(Resp_RdData),
    .WiFi_Port_Enable(WiFi_Port_Enable), .Bluetooth_Port_Enable(Bluetooth_Port_Enable),
    .WiFi_RST_n(WiFi_RST_n), .Uart_Reg(Uart_Reg), .Uart_Write(Uart_Write),
    .Uart_WrData(Uart_WrData), .Uart_RdData(Uart_RdData)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  port;
    logic [1:0]  wr;
    logic [5:0]  regs;
    logic [15:0] wdata;
    logic [7:0]  rdata;
    int          owner;
    int          lat;
    logic        err;
    logic [7:0]  exp_rd;
    int          wifi_cyc;
    int          bt_cyc;
    int          rst_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Req_Valid   = '0;
    Req_Port    = '0;
    Req_Write   = '0;
    Req_Reg     = '0;
    Req_WrData  = '0;
    Uart_RdData = '0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_H = 1'b1;
    clear_inputs();
    repeat (2) @(negedge Clock);
    Reset_H = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int k, lat, wc, bc, rc, viol;
    logic [1:0] rv;
    logic       rerr;
    logic [7:0] rrd;
    logic [2:0] ereg;
    logic       ewr;
    logic [7:0] ewd;
    @(negedge Clock);
    Req_Valid   = v.valid;
    Req_Port    = v.port;
    Req_Write   = v.wr;
    Req_Reg     = v.regs;
    Req_WrData  = v.wdata;
    Uart_RdData = ~v.rdata;
    #1;
    k = 0;
    while (Req_Ready == 2'b00 && k < 50) begin
      @(negedge Clock);
      #1;
      k++;
    end
    chk("grant", 32'(Req_Ready), 32'(2'b01 << v.owner));
    if (Req_Ready == 2'b00) begin
      Req_Valid = '0;
      return;
    end
    ereg = (v.owner == 1) ? v.regs[5:3] : v.regs[2:0];
    ewr  = (v.owner == 1) ? v.wr[1] : v.wr[0];
    ewd  = (v.owner == 1) ? v.wdata[15:8] : v.wdata[7:0];
    @(posedge Clock);
    #1;
    Req_Valid = '0;
    lat = 0; wc = 0; bc = 0; rc = 0; viol = 0;
    rv = '0; rerr = 1'b0; rrd = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge Clock);
      // Correct data is presented only in the last window cycle.
      Uart_RdData = (c == v.lat - 1) ? v.rdata : ~v.rdata;
      if (WiFi_Port_Enable) wc++;
      if (Bluetooth_Port_Enable) bc++;
      if (!WiFi_RST_n) rc++;
      if (WiFi_Port_Enable && Bluetooth_Port_Enable) viol++;
      if ((WiFi_Port_Enable || Bluetooth_Port_Enable) && !WiFi_RST_n) viol++;
      if (Req_Ready != 2'b00) viol++;
      if (WiFi_Port_Enable || Bluetooth_Port_Enable) begin
        if (Uart_Reg !== ereg || Uart_Write !== ewr || (ewr && Uart_WrData !== ewd)) viol++;
      end
      if (Resp_Valid != 2'b00) begin
        lat = c; rv = Resp_Valid; rerr = Resp_Err; rrd = Resp_RdData;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(v.lat));
    chk("resp_valid", 32'(rv), 32'(2'b01 << v.owner));
    chk("resp_err", 32'(rerr), 32'(v.err));
    chk("resp_rddata", 32'(rrd), 32'(v.exp_rd));
    chk("wifi_en_cycles", 32'(wc), 32'(v.wifi_cyc));
    chk("bt_en_cycles", 32'(bc), 32'(v.bt_cyc));
    chk("rst_low_cycles", 32'(rc), 32'(v.rst_cyc));
    chk("exclusivity", 32'(viol), 32'd0);
    @(negedge Clock);
    chk("resp_one_cycle", 32'(Resp_Valid), 32'd0);
  endtask

  vec_t tbl[7];
  vec_t rr;
  int   exp_owner[4];
  int   cnt;

  initial begin
    tbl[0] = '{2'b01, 4'b0000, 2'b00, 6'o05, 16'h0000, 8'h61, 0, ACC+1,  1'b0, 8'h61, ACC, 0, 0};
    tbl[1] = '{2'b10, 4'b0100, 2'b10, 6'o30, 16'hA500, 8'h77, 1, ACC+1,  1'b0, 8'h00, 0, ACC, 0};
    tbl[2] = '{2'b10, 4'b1000, 2'b00, 6'o00, 16'h0000, 8'h12, 1, RSTP+1, 1'b0, 8'h00, 0, 0, RSTP};
    tbl[3] = '{2'b01, 4'b0011, 2'b00, 6'o00, 16'h0000, 8'h34, 0, 1,      1'b1, 8'hFF, 0, 0, 0};
    tbl[4] = '{2'b01, 4'b0001, 2'b00, 6'o07, 16'h0000, 8'h3C, 0, ACC+1,  1'b0, 8'h3C, 0, ACC, 0};
    tbl[5] = '{2'b10, 4'b0000, 2'b00, 6'o00, 16'h0000, 8'hC3, 1, ACC+1,  1'b0, 8'hC3, ACC, 0, 0};
    tbl[6] = '{2'b01, 4'b0000, 2'b01, 6'o01, 16'h005A, 8'hEE, 0, ACC+1,  1'b0, 8'h00, ACC, 0, 0};
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    exp_owner = '{0, 0, 0, 0};
`else
    exp_owner = '{0, 1, 0, 1};
`endif

    // Reset state, with both requests asserted to show accept is held off during reset
    Reset_H = 1'b1;
    clear_inputs();
    Req_Valid = 2'b11;
    repeat (3) @(negedge Clock);
    chk("rst_req_ready", 32'(Req_Ready), 32'd0);
    chk("rst_resp", 32'({Resp_Valid, Resp_Err, Resp_RdData}), 32'd0);
    chk("rst_enables", 32'({WiFi_Port_Enable, Bluetooth_Port_Enable}), 32'd0);
    chk("rst_wifi_rst_n", 32'(WiFi_RST_n), 32'd1);
    chk("rst_uart", 32'({Uart_Reg, Uart_Write, Uart_WrData}), 32'd0);
    Reset_H = 1'b0;
    Req_Valid = '0;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Simultaneous requests after reset: req1 targets Bluetooth, req0 targets WiFi
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rr = '{2'b11, 4'b0100, 2'b00, 6'o42, 16'h0000, 8'(8'h10 + i), exp_owner[i], ACC+1,
             1'b0, 8'(8'h10 + i), (exp_owner[i] == 0) ? ACC : 0, (exp_owner[i] == 1) ? ACC : 0, 0};
      run_txn(rr);
    end

    // Reset during the second ACCESS cycle aborts the transaction silently
    do_reset();
    @(negedge Clock);
    Req_Valid = 2'b01; Req_Port = 4'b0000; Req_Write = 2'b00; Req_Reg = 6'o05;
    #1;
    cnt = 0;
    while (Req_Ready == 2'b00 && cnt < 50) begin
      @(negedge Clock);
      #1;
      cnt++;
    end
    chk("abort_grant", 32'(Req_Ready), 32'd1);
    @(posedge Clock);
    #1;
    Req_Valid = '0;
    @(negedge Clock);
    @(negedge Clock);
    chk("abort_en_before", 32'(WiFi_Port_Enable), 32'd1);
    Reset_H = 1'b1;
    @(negedge Clock);
    chk("abort_en_after", 32'(WiFi_Port_Enable), 32'd0);
    chk("abort_rst_n", 32'(WiFi_RST_n), 32'd1);
    Reset_H = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge Clock);
      if (Resp_Valid != 2'b00) cnt++;
    end
    chk("abort_no_resp", 32'(cnt), 32'd0);
    rr = '{2'b11, 4'b0100, 2'b00, 6'o00, 16'h0000, 8'h5E, 0, ACC+1, 1'b0, 8'h5E, ACC, 0, 0};
    run_txn(rr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/serial_port_arbiter.md
Name: serial_port_arbiter

Overview:
Shares the WiFi and Bluetooth 16550 UART register ports, plus the WiFi module reset line, between two bus requesters: req 0 is the CPU bridge and req 1 is the hardware link-poller. Each requester hands over one transaction at a time. The block grants requesters round-robin, drives the UART chip enable, register address and data for a fixed access window, and returns read data. It also generates a timed WiFi reset pulse on command. It sits between the requesters and the UART devices, replacing direct address decode of the serial ports.

Parameters:
ACCESS_CYCLES, 4, number of cycles the chip enable is held per register access (legal range 1..15)
RST_PULSE_CYCLES, 16, number of cycles WiFi_RST_n is held low per reset command (legal range 1..255)

Ports:
Clock  in  1  system clock
Reset_H  in  1  synchronous, active-high reset
Req_Valid  in  2  per requester: transaction request, held until accepted
Req_Ready  out  2  per requester: one-cycle accept pulse
Req_Port  in  4  2 bits per requester: 0=WiFi UART, 1=Bluetooth UART, 2=WiFi reset, 3=illegal
Req_Write  in  2  per requester: 1=write, 0=read
Req_Reg  in  6  3 bits per requester: 16550 register index
Req_WrData  in  16  8 bits per requester: write data
Resp_Valid  out  2  per requester: one-cycle completion pulse
Resp_Err  out  1  qualifies Resp_Valid: 1 = illegal port
Resp_RdData  out  8  read data, valid with Resp_Valid
WiFi_Port_Enable  out  1  active-high WiFi UART chip enable
Bluetooth_Port_Enable  out  1  active-high Bluetooth UART chip enable
WiFi_RST_n  out  1  active-low WiFi module reset
Uart_Reg  out  3  register index to the UARTs
Uart_Write  out  1  1 = write strobe phase
Uart_WrData  out  8  write data to the UARTs
Uart_RdData  in  8  read data from the selected UART

Behaviour:
- Reset values: Req_Ready=0, Resp_Valid=0, Resp_Err=0, Resp_RdData=0, both enables=0, WiFi_RST_n=1, Uart_Reg=0, Uart_Write=0, Uart_WrData=0, state=IDLE, last-grant pointer=1 (so req 0 wins first).
- Reset asserted mid-operation: abort immediately. Enables drop and WiFi_RST_n returns high on the next edge. No Resp_Valid is issued for the aborted transaction.
- FSM states: IDLE, ACCESS, PULSE, RESPOND.
- IDLE:
  - Neither requester valid: stay in IDLE.
  - One requester valid: grant it.
  - Both valid: grant the requester not equal to the last-grant pointer.
  - On grant: Req_Ready[winner]=1 for one cycle (cycle T), latch that requester's port/write/reg/data, update the pointer.
  - Next state: port 0/1 -> ACCESS; port 2 -> PULSE; port 3 -> RESPOND with Resp_Err=1 and Resp_RdData=0xFF.
- ACCESS:
  - Selected enable high for exactly ACCESS_CYCLES cycles (T+1..T+ACCESS_CYCLES).
  - Uart_Reg, Uart_Write and Uart_WrData stable for the whole window.
  - Read: Uart_RdData captured on the last window cycle. Write: Resp_RdData=0x00.
  - Then -> RESPOND.
- PULSE: WiFi_RST_n low for exactly RST_PULSE_CYCLES cycles (T+1..T+RST_PULSE_CYCLES), no enables, then -> RESPOND with Resp_RdData=0x00.
- RESPOND: Resp_Valid[owner]=1 for one cycle, then -> IDLE. The next grant can occur no earlier than the cycle after RESPOND.
- Latency, accept to Resp_Valid: ACCESS_CYCLES+1 (UART), RST_PULSE_CYCLES+1 (reset), 1 (illegal).
- Exclusivity:
  - At most one enable high at any time.
  - Enables never high while WiFi_RST_n=0.
  - Req_Ready never asserted outside IDLE.
- Requests arriving while busy wait; Req_Valid deasserted before accept is simply dropped.
- Counters are sized for the parameter maxima; no wrap is possible within a transaction.

Optional Feature:
SERIAL_ARB_FIXED_PRIO_EN:
- Defined: requester 0 always wins simultaneous requests; the last-grant pointer is unused. Req 1 can starve, which is accepted for this mode.
- Undefined: round-robin as specified above.

Test Plan:
- Req0 read, port 0, reg 5, Uart_RdData=0x61 -> Req_Ready[0] at T; WiFi_Port_Enable high T+1..T+4; Resp_Valid[0] at T+5 with Resp_RdData=0x61, Resp_Err=0.
- Both requesters valid in the same cycle, repeated three times -> grants in order 0,1,0; never two enables high at once.
- Req1 port 2 -> WiFi_RST_n low exactly 16 cycles; no enable high during the pulse; Resp_Valid[1] at T+17.
- Req0 port 3 -> no enable high and WiFi_RST_n stays 1; Resp_Valid[0] at T+1 with Resp_Err=1, Resp_RdData=0xFF.
- Reset_H pulsed during cycle 2 of an ACCESS -> enable low on the next edge, no Resp_Valid; the next simultaneous request is granted to req 0.
- SERIAL_ARB_FIXED_PRIO_EN defined, both requesters valid for 4 transactions -> all four granted to req 0.
